// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State encoding doubles as the debug value driven on the state port.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit ALU operation.
// Unknown funct codes quietly fall back to add.
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and enables,
// plus a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic         zero,
    output logic         iord,
    output logic         memwrite,
    output logic         irwrite,
    output logic         regdst,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         alusrca,
    output logic [1:0]   alusrcb,
    output logic [1:0]   pcsrc,
    output logic [2:0]   alucontrol,
    output logic         pcen,
    output logic [3:0]   state,
    output logic [n-1:0] instret
);

    state_t         r_state;
    state_t         w_next;
    ctrl_t          w_ctrl;
    logic [n-1:0]   r_instret;
    logic           w_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Illegal encodings land in the default arm: every enable stays low.
    always_comb begin
        w_ctrl       = '0;
        w_ctrl.aluop = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ctrl.alusrcb = SRCB_FOUR;
                w_ctrl.pcsrc   = PC_ALU;
                w_ctrl.irwrite = 1'b1;
                w_ctrl.pcwrite = 1'b1;
            end
            S_DECODE:  w_ctrl.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD:   w_ctrl.iord = 1'b1;
            S_MEMWB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_RT;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_RT;
                w_ctrl.aluop   = ALUOP_SUB;
                w_ctrl.pcsrc   = PC_ALUOUT;
                w_ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
            end
            S_ADDIWB:  w_ctrl.regwrite = 1'b1;
            S_JEX: begin
                w_ctrl.pcsrc   = PC_JUMP;
                w_ctrl.pcwrite = 1'b1;
            end
            default:   w_ctrl = '0;
        endcase
    end

    aludec u_aludec (
        .aluop      (w_ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Reset masks the state-changing strobes so nothing commits while held.
    assign iord     = w_ctrl.iord;
    assign memwrite = w_ctrl.memwrite & ~rst;
    assign irwrite  = w_ctrl.irwrite  & ~rst;
    assign regdst   = w_ctrl.regdst;
    assign memtoreg = w_ctrl.memtoreg;
    assign regwrite = w_ctrl.regwrite & ~rst;
    assign alusrca  = w_ctrl.alusrca;
    assign alusrcb  = w_ctrl.alusrcb;
    assign pcsrc    = w_ctrl.pcsrc;
    assign pcen     = (w_ctrl.pcwrite | (w_ctrl.branch & zero)) & ~rst;
    assign state    = r_state;

    assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + n'(1);
    end

    assign instret = r_instret;

endmodule
